// File: rtl/sc_sidemove_controller_if.sv
// Button/position bundle between the debounced inputs, the sidemove sequencer and the playfield.
// master drives the active-low requests; slave is the sequencer side.
interface sc_sidemove_controller_if #(
    parameter int unsigned SIDEMOVE_DATAWIDTH = 4
);
    logic                          SC_SIDEMOVE_left_InLow;
    logic                          SC_SIDEMOVE_right_InLow;
    logic                          SC_SIDEMOVE_load_InLow;
    logic [SIDEMOVE_DATAWIDTH-1:0] SC_SIDEMOVE_data_OutBUS;
    logic                          SC_SIDEMOVE_side_OutLow;
    logic                          SC_SIDEMOVE_blocked_Out;
    logic                          SC_SIDEMOVE_busy_Out;

    modport master (
        output SC_SIDEMOVE_left_InLow,
        output SC_SIDEMOVE_right_InLow,
        output SC_SIDEMOVE_load_InLow,
        input  SC_SIDEMOVE_data_OutBUS,
        input  SC_SIDEMOVE_side_OutLow,
        input  SC_SIDEMOVE_blocked_Out,
        input  SC_SIDEMOVE_busy_Out
    );

    modport slave (
        input  SC_SIDEMOVE_left_InLow,
        input  SC_SIDEMOVE_right_InLow,
        input  SC_SIDEMOVE_load_InLow,
        output SC_SIDEMOVE_data_OutBUS,
        output SC_SIDEMOVE_side_OutLow,
        output SC_SIDEMOVE_blocked_Out,
        output SC_SIDEMOVE_busy_Out
    );
endinterface

// File: rtl/sc_sidemove_controller.sv
// Lateral-move sequencer for the car lane register: IDLE -> SHIFT -> COOLDOWN with auto-repeat.
// Define SIDEMOVE_WRAP_EN to rotate at the sides instead of refusing outward moves.
module sc_sidemove_controller #(
    parameter int unsigned                 SIDEMOVE_DATAWIDTH = 4,
    parameter int unsigned                 SIDEMOVE_REPEAT    = 8,
    parameter logic [SIDEMOVE_DATAWIDTH-1:0] SIDEMOVE_STARTPOS  = SIDEMOVE_DATAWIDTH'(4'b0100)
) (
    input logic                     SC_SIDEMOVE_CLOCK_50,
    input logic                     SC_SIDEMOVE_RESET_InLow,
    sc_sidemove_controller_if.slave bus
);
    localparam int unsigned W    = SIDEMOVE_DATAWIDTH;
    localparam int unsigned CntW = $clog2(SIDEMOVE_REPEAT) + 1;
    localparam logic [CntW-1:0] CntReload = CntW'(SIDEMOVE_REPEAT - 1);
    localparam logic [W-1:0]    LsbOnly   = W'(1);
    localparam logic [W-1:0]    MsbOnly   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StShift, StCooldown} state_e;

    state_e          stateQ, stateD;
    logic [W-1:0]    dataQ, dataD;
    logic [CntW-1:0] cntQ, cntD;
    logic            dirQ, dirD;
    logic            blockedQ, blockedD;

    logic            leftReq, rightReq, loadReq;
    logic            outwardBlocked;
    logic [W-1:0]    shiftedLeft, shiftedRight;

    assign leftReq  = ~bus.SC_SIDEMOVE_left_InLow;
    assign rightReq = ~bus.SC_SIDEMOVE_right_InLow;
    assign loadReq  = ~bus.SC_SIDEMOVE_load_InLow;

`ifdef SIDEMOVE_WRAP_EN
    // Rotation makes every move legal, so nothing is ever refused.
    assign shiftedLeft    = {dataQ[W-2:0], dataQ[W-1]};
    assign shiftedRight   = {dataQ[0], dataQ[W-1:1]};
    assign outwardBlocked = 1'b0;
`else
    assign shiftedLeft    = dataQ << 1;
    assign shiftedRight   = dataQ >> 1;
    assign outwardBlocked = (leftReq & dataQ[W-1]) | (rightReq & dataQ[0]);
`endif

    always_comb begin
        stateD   = stateQ;
        dataD    = dataQ;
        cntD     = cntQ;
        dirD     = dirQ;
        blockedD = 1'b0;
        case (stateQ)
            StIdle: begin
                if (loadReq) begin
                    dataD = SIDEMOVE_STARTPOS;
                end else if (leftReq ^ rightReq) begin
                    if (outwardBlocked) begin
                        blockedD = 1'b1;
                    end else begin
                        dirD   = leftReq;
                        stateD = StShift;
                    end
                end
            end
            StShift: begin
                if (loadReq) begin
                    dataD  = SIDEMOVE_STARTPOS;
                    stateD = StIdle;
                end else begin
                    dataD  = dirQ ? shiftedLeft : shiftedRight;
                    cntD   = CntReload;
                    stateD = StCooldown;
                end
            end
            StCooldown: begin
                if (loadReq) begin
                    dataD  = SIDEMOVE_STARTPOS;
                    cntD   = '0;
                    stateD = StIdle;
                end else if (cntQ == '0) begin
                    stateD = StIdle;
                end else begin
                    cntD = cntQ - 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge SC_SIDEMOVE_CLOCK_50) begin
        if (!SC_SIDEMOVE_RESET_InLow) begin
            stateQ   <= StIdle;
            dataQ    <= SIDEMOVE_STARTPOS;
            cntQ     <= '0;
            dirQ     <= 1'b0;
            blockedQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            dataQ    <= dataD;
            cntQ     <= cntD;
            dirQ     <= dirD;
            blockedQ <= blockedD;
        end
    end

    assign bus.SC_SIDEMOVE_data_OutBUS = dataQ;
    assign bus.SC_SIDEMOVE_side_OutLow = ~((dataQ == MsbOnly) | (dataQ == LsbOnly));
    assign bus.SC_SIDEMOVE_blocked_Out = blockedQ;
    assign bus.SC_SIDEMOVE_busy_Out    = (stateQ != StIdle);
endmodule
